serial_link: RTL and testbench

- Game Boy link-port serial controller.
- Implements SB (FF01) and SC (FF02) and sits beside the timer on the CPU register bus.
- Produces the 1-clock serial interrupt pulse that drives interrupt flag bit 3 in the top level.
- Shifts 8 bits MSB-first, using either its own 8192 Hz bit clock (internal) or a clock driven by the link partner (external).

---
 rtl/serial_link.sv | 167 ++++++++++++++++
 tb/tb_serial_link.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_link.sv
// Game Boy link-port serial controller (SB/SC registers, 8-bit MSB-first shifter).
// Internal 8192 Hz bit clock or partner-driven external clock; 1-clk irq on completion.
module serial_link #(
  parameter int CLK_DIV = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_sel,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       irq,
  output logic       ser_clk_out,
  output logic       ser_clk_oe,
  input  logic       ser_clk_in,
  output logic       ser_data_out,
  input  logic       ser_data_in
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state, state_n;
  logic [7:0]    sb, sb_n;
  logic          sc_start, start_n;
  logic          sc_int, int_n;
  logic [2:0]    bit_cnt, cnt_n;
  logic [DW-1:0] div, div_n;
  logic          prime, prime_n;
  logic          cko_n, dout_n, irq_n;

  logic [2:0] clk_sync;
  logic [1:0] dat_sync;
  logic       ext_rise, ext_fall;
  logic       din;
  logic       wr_sb, wr_sc;

  assign ext_rise = clk_sync[1] & ~clk_sync[2];
  assign ext_fall = ~clk_sync[1] & clk_sync[2];
  assign din      = dat_sync[1];
  assign wr_sb    = cpu_sel & cpu_wr & (cpu_addr == 2'b01);
  assign wr_sc    = cpu_sel & cpu_wr & (cpu_addr == 2'b10);

  assign ser_clk_oe = sc_int;

  always_comb begin
    cpu_do = 8'hFF;
    unique case (1'b1)
      cpu_addr == 2'b01: cpu_do = sb;
      cpu_addr == 2'b10: cpu_do = {sc_start, 6'b111111, sc_int};
      default:           cpu_do = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ser_clk_in};
      dat_sync <= {dat_sync[0], ser_data_in};
    end
  end

  always_comb begin
    logic rise, fall;
    rise    = 1'b0;
    fall    = 1'b0;
    state_n = state;
    sb_n    = sb;
    start_n = sc_start;
    int_n   = sc_int;
    cnt_n   = bit_cnt;
    div_n   = div;
    prime_n = prime;
    cko_n   = ser_clk_out;
    dout_n  = ser_data_out;
    irq_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (wr_sb) sb_n = cpu_di;
      end
      SHIFT: begin
        if (sc_int) begin
          // one settle cycle after start so the 8th shift lands at 1+15*CLK_DIV
          if (prime) begin
            prime_n = 1'b0;
          end else if (div == DW'(CLK_DIV - 1)) begin
            div_n = '0;
            cko_n = ~ser_clk_out;
            rise  = ~ser_clk_out;
            fall  = ser_clk_out;
          end else begin
            div_n = div + DW'(1);
          end
        end else begin
          rise = ext_rise;
          fall = ext_fall;
        end
        if (fall) dout_n = sb[7];
        if (rise) begin
          sb_n  = {sb[6:0], din};
          cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            irq_n   = 1'b1;
            start_n = 1'b0;
            state_n = IDLE;
            cko_n   = 1'b1;
            cnt_n   = 3'd0;
            if (wr_sb) sb_n = cpu_di;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // SC writes override any completion: start/restart or abort
    if (wr_sc) begin
      start_n = cpu_di[7];
      int_n   = cpu_di[0];
      if (cpu_di[7]) begin
        state_n = SHIFT;
        cnt_n   = 3'd0;
        div_n   = '0;
        prime_n = 1'b1;
        dout_n  = sb_n[7];
        cko_n   = ~cpu_di[0];
      end else begin
        state_n = IDLE;
        cko_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sb           <= 8'h00;
      sc_start     <= 1'b0;
      sc_int       <= 1'b0;
      bit_cnt      <= 3'd0;
      div          <= '0;
      prime        <= 1'b0;
      ser_clk_out  <= 1'b1;
      ser_data_out <= 1'b1;
      irq          <= 1'b0;
    end else begin
      state        <= state_n;
      sb           <= sb_n;
      sc_start     <= start_n;
      sc_int       <= int_n;
      bit_cnt      <= cnt_n;
      div          <= div_n;
      prime        <= prime_n;
      ser_clk_out  <= cko_n;
      ser_data_out <= dout_n;
      irq          <= irq_n;
    end
  end

endmodule

// File: tb/tb_serial_link.sv
// Directed bench for serial_link with CLK_DIV=4.
// Loopback, external clock, abort, restart and completion-collision cases.
module tb_serial_link;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_sel = 1'b0;
  logic [1:0] cpu_addr = 2'b00;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_di = 8'h00;
  logic [7:0] cpu_do;
  logic       irq;
  logic       ser_clk_out;
  logic       ser_clk_oe;
  logic       ser_clk_in = 1'b1;
  logic       ser_data_out;
  logic       ser_data_in;
  logic       loop = 1'b0;
  logic       din_drv = 1'b1;

  int vecs = 0;
  int errs = 0;
  int irq_cnt = 0;
  int rises = 0;
  logic cko_q = 1'b1;

  assign ser_data_in = loop ? ser_data_out : din_drv;

  serial_link #(.CLK_DIV(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr),
    .cpu_di(cpu_di),
    .cpu_do(cpu_do),
    .irq(irq),
    .ser_clk_out(ser_clk_out),
    .ser_clk_oe(ser_clk_oe),
    .ser_clk_in(ser_clk_in),
    .ser_data_out(ser_data_out),
    .ser_data_in(ser_data_in)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irq) irq_cnt++;
    if (ser_clk_out && !cko_q) rises++;
    cko_q <= ser_clk_out;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_di = d;
    @(posedge clk);
    #1;
    cpu_sel = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    cpu_addr = a;
    #1;
    d = cpu_do;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        n = i;
        break;
      end
    end
  endtask

  logic [7:0] rd;
  logic [7:0] pat_out;
  logic [7:0] pat_in;
  int n, c0;

  initial begin
    repeat (3) @(posedge clk);
    reset_n = 1'b1;

    // reset asserted mid-transfer
    cpu_write(2'b01, 8'hA5);
    cpu_write(2'b10, 8'h81);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    cpu_read(2'b01, rd); check("rst_sb", rd, 8'h00);
    cpu_read(2'b10, rd); check("rst_sc", rd, 8'h7E);
    check("rst_cko", ser_clk_out, 1'b1);
    check("rst_dout", ser_data_out, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_oe", ser_clk_oe, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // internal loopback
    loop = 1'b1;
    c0 = irq_cnt;
    cpu_write(2'b01, 8'hA5);
    cpu_write(2'b10, 8'h81);
    check("lb_oe", ser_clk_oe, 1'b1);
    wait_irq(n);
    check("lb_lat", n, 61);
    repeat (5) @(posedge clk);
    check("lb_irqs", irq_cnt - c0, 1);
    cpu_read(2'b01, rd); check("lb_sb", rd, 8'hA5);
    cpu_read(2'b10, rd); check("lb_sc", rd, 8'h7F);
    check("lb_cko", ser_clk_out, 1'b1);

    // external clock from partner
    loop = 1'b0;
    c0 = irq_cnt;
    pat_out = 8'h3C;
    pat_in = 8'h5A;
    cpu_write(2'b01, 8'h3C);
    cpu_write(2'b10, 8'h80);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ser_clk_in = 1'b0;
      din_drv = pat_in[7-k];
      repeat (6) @(negedge clk);
      check($sformatf("ext_out%0d", k), ser_data_out, pat_out[7-k]);
      ser_clk_in = 1'b1;
      repeat (6) @(negedge clk);
    end
    check("ext_oe", ser_clk_oe, 1'b0);
    check("ext_cko", ser_clk_out, 1'b1);
    check("ext_irqs", irq_cnt - c0, 1);
    cpu_read(2'b01, rd); check("ext_sb", rd, 8'h5A);
    cpu_read(2'b10, rd); check("ext_sc", rd, 8'h7E);

    // abort after three rising link clocks
    c0 = irq_cnt;
    din_drv = 1'b0;
    cpu_write(2'b01, 8'hFF);
    rises = 0;
    cpu_write(2'b10, 8'h81);
    for (int i = 0; i < 200 && rises < 3; i++) @(negedge clk);
    check("ab_rises", rises, 3);
    cpu_write(2'b10, 8'h01);
    repeat (100) @(posedge clk);
    #1;
    check("ab_irqs", irq_cnt - c0, 0);
    check("ab_cko", ser_clk_out, 1'b1);
    cpu_read(2'b01, rd); check("ab_sb", rd, 8'hF8);
    cpu_read(2'b10, rd); check("ab_sc", rd, 8'h7F);

    // ignored SB write then restart
    loop = 1'b1;
    cpu_write(2'b01, 8'hA5);
    c0 = irq_cnt;
    cpu_write(2'b10, 8'h81);
    repeat (6) @(posedge clk);
    cpu_write(2'b01, 8'h12);
    cpu_read(2'b01, rd); check("rs_sbign", rd, 8'h4B);
    cpu_write(2'b10, 8'h81);
    wait_irq(n);
    check("rs_lat", n, 61);
    repeat (5) @(posedge clk);
    check("rs_irqs", irq_cnt - c0, 1);
    cpu_read(2'b01, rd); check("rs_sb", rd, 8'h4B);

    // SC write on the completion edge
    c0 = irq_cnt;
    cpu_write(2'b10, 8'h81);
    repeat (60) @(posedge clk);
    cpu_write(2'b10, 8'h81);
    check("col_irq", irq, 1'b1);
    cpu_read(2'b10, rd); check("col_sc", rd, 8'hFF);
    wait_irq(n);
    check("col_lat", n, 61);
    repeat (5) @(posedge clk);
    check("col_irqs", irq_cnt - c0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
